// File: rtl/byte_pack_pkg.sv
// Shared types and helpers for the byte-to-word packer.
package byte_pack_pkg;

    localparam int MAX_BYTES_PER_WORD = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2
    } pack_state_e;

    function automatic logic [MAX_BYTES_PER_WORD-1:0] keep_mask(input logic [3:0] count);
        logic [MAX_BYTES_PER_WORD-1:0] m;
        m = '0;
        for (int k = 0; k < MAX_BYTES_PER_WORD; k++) begin
            m[k] = (k < int'(count));
        end
        return m;
    endfunction

endpackage

// File: rtl/word_hold_reg.sv
// Single-entry valid/ready holding register; output registered, one-cycle load latency.
// Accepts a new entry when empty or draining in the same cycle; contents stable while stalled.
module word_hold_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_vld,
    output logic         o_rdy,
    input  logic [W-1:0] i_dat,
    output logic         o_vld,
    input  logic         i_rdy,
    output logic [W-1:0] o_dat
);

    logic         r_vld;
    logic [W-1:0] r_dat;
    logic         w_load;

    assign o_rdy  = !r_vld || i_rdy;
    assign w_load = i_vld && o_rdy;
    assign o_vld  = r_vld;
    assign o_dat  = r_dat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= 1'b0;
            r_dat <= '0;
        end else if (w_load) begin
            r_vld <= 1'b1;
            r_dat <= i_dat;
        end else if (i_rdy) begin
            r_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/byte_word_packer.sv
// Packs a little-endian byte stream into BYTES_PER_WORD words; word valid one edge after its last byte.
// Hold register plus accumulator absorb 2N bytes under backpressure, then in_ready drops.
module byte_word_packer
    import byte_pack_pkg::*;
#(
    parameter int BYTES_PER_WORD = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        flush,
    output logic [8*BYTES_PER_WORD-1:0] out_data,
    output logic [BYTES_PER_WORD-1:0]   out_keep,
    output logic                        out_last,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int N  = BYTES_PER_WORD;
    localparam int DW = 8 * N;
    localparam int HW = DW + N + 1;
    localparam logic [3:0] LAST_LANE = 4'(N - 1);

    pack_state_e r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [DW-1:0] r_data, w_data_nxt, w_word_data;
    logic [N-1:0]  r_keep, w_keep_nxt, w_keep_new;
    logic          r_last, w_last_nxt;

    logic [MAX_BYTES_PER_WORD-1:0] w_keep_full;
    logic [N-1:0]  w_lane_we;
    logic [3:0]    w_bytes_now;
    logic          w_acc, w_complete, w_hold_rdy;
    logic          w_push, w_push_last;
    logic [DW-1:0] w_push_data;
    logic [N-1:0]  w_push_keep;
    logic [HW-1:0] w_hold_dat, w_out_dat;

    assign in_ready    = !rst && (r_state != FULL);
    assign w_acc       = in_valid && in_ready;
    assign w_bytes_now = r_cnt + {3'b000, w_acc};
    assign w_keep_full = keep_mask(w_bytes_now);
    assign w_keep_new  = w_keep_full[N-1:0];
    assign w_complete  = (r_state != FULL) &&
                         ((w_acc && (r_cnt == LAST_LANE)) || (flush && (w_bytes_now != 4'd0)));

    always_comb begin
        w_lane_we   = '0;
        w_word_data = r_data;
        for (int k = 0; k < N; k++) begin
            w_lane_we[k] = w_acc && (r_cnt == 4'(k));
            if (w_lane_we[k]) begin
                w_word_data[8*k +: 8] = in_data;
            end
        end
    end

    // A parked word keeps its own keep mask; a late flush only adds the last marker.
    always_comb begin
        w_push      = 1'b0;
        w_push_data = w_word_data;
        w_push_keep = w_keep_new;
        w_push_last = flush;
        if (r_state == FULL) begin
            w_push      = 1'b1;
            w_push_data = r_data;
            w_push_keep = r_keep;
            w_push_last = r_last || flush;
        end else begin
            w_push = w_complete;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_data_nxt  = r_data;
        w_keep_nxt  = r_keep;
        w_last_nxt  = r_last;
        case (r_state)
            FULL: begin
                if (w_hold_rdy) begin
                    w_state_nxt = EMPTY;
                    w_cnt_nxt   = 4'd0;
                    w_data_nxt  = '0;
                    w_keep_nxt  = '0;
                    w_last_nxt  = 1'b0;
                end else if (flush) begin
                    w_last_nxt = 1'b1;
                end
            end
            default: begin
                if (w_complete) begin
                    w_cnt_nxt = 4'd0;
                    if (w_hold_rdy) begin
                        w_state_nxt = EMPTY;
                        w_data_nxt  = '0;
                        w_keep_nxt  = '0;
                        w_last_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = FULL;
                        w_data_nxt  = w_word_data;
                        w_keep_nxt  = w_keep_new;
                        w_last_nxt  = flush;
                    end
                end else if (w_acc) begin
                    w_state_nxt = FILL;
                    w_cnt_nxt   = r_cnt + 4'd1;
                    w_data_nxt  = w_word_data;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
            r_cnt   <= 4'd0;
            r_data  <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_data  <= w_data_nxt;
            r_keep  <= w_keep_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign w_hold_dat = {w_push_data, w_push_keep, w_push_last};

    word_hold_reg #(
        .W (HW)
    ) u_hold (
        .clk   (clk),
        .rst   (rst),
        .i_vld (w_push),
        .o_rdy (w_hold_rdy),
        .i_dat (w_hold_dat),
        .o_vld (out_valid),
        .i_rdy (out_ready),
        .o_dat (w_out_dat)
    );

    assign out_data = w_out_dat[HW-1 -: DW];
    assign out_keep = w_out_dat[N:1];
    assign out_last = w_out_dat[0];

endmodule

// File: tb/tb_byte_word_packer.sv
// Scoreboard bench for byte_word_packer with N=4.
module tb_byte_word_packer;

    localparam int N = 4;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic        out_valid;
    logic        out_ready = 1'b1;

    int    n_checks = 0;
    int    n_pass   = 0;
    word_t exp_q[$];
    word_t mon_e;
    logic [31:0] m_acc = '0;
    int          m_cnt = 0;

    byte_word_packer #(.BYTES_PER_WORD(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    // Output side of the scoreboard: every word transfer is popped and compared.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_word: got data=%h keep=%h last=%b, required no output",
                         out_data, out_keep, out_last);
            end else begin
                mon_e = exp_q.pop_front();
                if ({out_data, out_keep, out_last} !== mon_e) begin
                    $display("FAIL word: got data=%h keep=%h last=%b, required data=%h keep=%h last=%b",
                             out_data, out_keep, out_last, mon_e.data, mon_e.keep, mon_e.last);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    task automatic model_accept(input logic [7:0] b, input logic fl);
        word_t w;
        m_acc[8*m_cnt +: 8] = b;
        m_cnt++;
        if (m_cnt == N || fl) begin
            w.data = m_acc;
            w.keep = 4'((1 << m_cnt) - 1);
            w.last = fl;
            exp_q.push_back(w);
            m_acc = '0;
            m_cnt = 0;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the byte is taken.
    task automatic send_byte(input logic [7:0] b, input logic fl, output int stalls);
        int   guard;
        logic acc;
        in_data  = b;
        in_valid = 1'b1;
        flush    = fl;
        stalls   = 0;
        guard    = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            stalls++;
            guard++;
            @(negedge clk);
        end
        acc = in_ready;
        if (!acc) begin
            n_checks++;
            $display("FAIL send_timeout: byte %h not accepted after %0d cycles, required acceptance", b, guard);
        end
        @(posedge clk);
        if (acc) model_accept(b, fl);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic flush_alone();
        word_t w;
        in_valid = 1'b0;
        flush    = 1'b1;
        @(posedge clk);
        if (m_cnt > 0) begin
            w.data = m_acc;
            w.keep = 4'((1 << m_cnt) - 1);
            w.last = 1'b1;
            exp_q.push_back(w);
            m_acc = '0;
            m_cnt = 0;
        end
        #1;
        flush = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b, required 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== 32'h0) $display("FAIL reset_out_data: got %h, required 00000000", out_data); else n_pass++;
        n_checks++; if (out_keep !== 4'h0) $display("FAIL reset_out_keep: got %h, required 0", out_keep); else n_pass++;
        n_checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last: got %b, required 0", out_last); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b, required 0", in_ready); else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) $display("FAIL release_in_ready: got %b, required 1", in_ready); else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_continuous();
        int st, total;
        total = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_byte(8'(8'h11 * (i + 1)), 1'b0, st);
            total += st;
        end
        n_checks++; if (total !== 0) $display("FAIL continuous_stalls: got %0d, required 0", total); else n_pass++;
        drain();
        n_checks++; if (exp_q.size() !== 0) $display("FAIL continuous_pending: got %0d words left, required 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_flushes();
        int st;
        send_byte(8'hAA, 1'b0, st);
        send_byte(8'hBB, 1'b0, st);
        flush_alone();
        send_byte(8'h01, 1'b0, st);
        send_byte(8'h02, 1'b0, st);
        send_byte(8'h03, 1'b1, st);
        send_byte(8'h11, 1'b0, st);
        send_byte(8'h22, 1'b0, st);
        send_byte(8'h33, 1'b0, st);
        send_byte(8'h44, 1'b1, st);
        drain();
        n_checks++; if (exp_q.size() !== 0) $display("FAIL flush_pending: got %0d words left, required 0", exp_q.size()); else n_pass++;
        flush_alone();
        repeat (8) @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_empty: got out_valid=%b, required 0", out_valid); else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        int          st, total, bad;
        logic [31:0] snap;
        total = 0;
        bad   = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_byte(8'(8'hB0 + i), 1'b0, st);
            total += st;
        end
        n_checks++; if (total !== 0) $display("FAIL bp_absorb_stalls: got %0d, required 0", total); else n_pass++;
        in_data  = 8'hB8;
        in_valid = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b, required 0", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid: got %b, required 1", out_valid); else n_pass++;
        snap = out_data;
        repeat (4) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || out_data !== snap) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL bp_hold_stable: got %0d unstable cycles, required 0", bad); else n_pass++;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 8; i < 12; i++) send_byte(8'(8'hB0 + i), 1'b0, st);
        drain();
        n_checks++; if (exp_q.size() !== 0) $display("FAIL bp_pending: got %0d words left, required 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_flush_in_full();
        int    st;
        word_t w;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_byte(8'(8'hE0 + i), 1'b0, st);
        flush_alone();
        w = exp_q.pop_back();
        w.last = 1'b1;
        exp_q.push_back(w);
        out_ready = 1'b1;
        drain();
        n_checks++; if (exp_q.size() !== 0) $display("FAIL full_flush_pending: got %0d words left, required 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_reset_midword();
        int st, bad;
        bad = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_byte(8'(8'hD0 + i), 1'b0, st);
        #1;
        rst = 1'b1;
        exp_q.delete();
        m_acc = '0;
        m_cnt = 0;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b, required 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== 32'h0) $display("FAIL midrst_out_data: got %h, required 00000000", out_data); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL midrst_in_ready: got %b, required 0", in_ready); else n_pass++;
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL midrst_spurious: got %0d valid cycles, required 0", bad); else n_pass++;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 4; i++) send_byte(8'(8'hC0 + i), 1'b0, st);
        drain();
        n_checks++; if (exp_q.size() !== 0) $display("FAIL midrst_pending: got %0d words left, required 0", exp_q.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_flushes();
        test_backpressure();
        test_flush_in_full();
        test_reset_midword();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
